// File: rtl/rvdff_skid_pkg.sv
// Shared definitions for the rvdff_skid elastic stage: state encoding,
// occupancy width and default payload width.
package rvdff_skid_pkg;

    // Encoding is {skid_v, main_v}; 2'b10 is unreachable by construction.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    localparam int CNT_W         = 2;
    localparam int DEFAULT_WIDTH = 16;

    function automatic logic [CNT_W-1:0] state_count(input state_e s);
        logic [CNT_W-1:0] c;
        c = '0;
        case (s)
            EMPTY:   c = 2'd0;
            ONE:     c = 2'd1;
            FULL:    c = 2'd2;
            default: c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/rvdff_skid_rvdffe.sv
// Enabled payload flop; optionally cleared by the synchronous active-low reset.
module rvdffe #(
    parameter int WIDTH      = 16,
    parameter int DATA_RESET = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_ff @(posedge clock) begin
        if ((DATA_RESET != 0) && !reset) begin
            dout <= '0;
        end else if (en) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/rvdff_skid.sv
// Two-entry skid buffer feeding the rvdff flop stage; ready toward the
// producer comes from a flop so out_ready never reaches in_ready combinationally.
module rvdff_skid
    import rvdff_skid_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DATA_RESET = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_flush,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_bits,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_bits,
    output logic [CNT_W-1:0] io_count,
    output logic             io_clken
);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] count_q;
    logic             main_v;
    logic             skid_v;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign main_v = state_q[0];
    assign skid_v = state_q[1];

    // Reset gating is the only non-flop term on in_ready.
    assign io_in_ready  = reset & ~skid_v;
    assign io_out_valid = main_v;
    assign io_out_bits  = main_q;
    assign io_count     = count_q;

    assign in_fire  = io_in_valid & io_in_ready;
    assign out_fire = main_v & io_out_ready;
    assign io_clken = in_fire | out_fire | io_flush;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= EMPTY;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= state_count(state_d);
        end
    end

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = io_in_bits;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_en = 1'b1;
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // A flush discards anything accepted this cycle, so payloads hold.
        if (io_flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
    end

    rvdffe #(
        .WIDTH      (WIDTH),
        .DATA_RESET (DATA_RESET)
    ) u_main (
        .clock (clock),
        .reset (reset),
        .en    (main_en),
        .din   (main_d),
        .dout  (main_q)
    );

    rvdffe #(
        .WIDTH      (WIDTH),
        .DATA_RESET (DATA_RESET)
    ) u_skid (
        .clock (clock),
        .reset (reset),
        .en    (skid_en),
        .din   (io_in_bits),
        .dout  (skid_q)
    );

endmodule

// File: doc/rvdff_skid.md
Name: rvdff_skid

Overview:
- Two-entry elastic pipeline stage (skid buffer) with valid/ready handshake on both sides; sits directly upstream of the rvdff sequential data flop stage and feeds it.
- Registers ready toward the producer, so no combinational path from io_out_ready to io_in_ready.
- Exports an activity/clock-enable hint for the downstream flop.
- Supports a synchronous pipeline flush.

Parameters:
- WIDTH, 16, payload width in bits.
- DATA_RESET, 0, 1 = payload registers clear to 0 on reset; 0 = payload registers not reset.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low: low at a rising edge resets the block.
- io_flush  in  1  synchronous flush, active-high.
- io_in_valid  in  1  producer has data.
- io_in_ready  out  1  block can accept; registered, except forced 0 while reset is low.
- io_in_bits  in  WIDTH  producer payload.
- io_out_valid  out  1  io_out_bits is valid; registered.
- io_out_ready  in  1  consumer accepts.
- io_out_bits  out  WIDTH  payload, driven directly from the main register.
- io_count  out  2  occupancy, 0..2.
- io_clken  out  1  high in any cycle with in_fire, out_fire or io_flush.

Behaviour:
- Definitions:
  - in_fire = io_in_valid & io_in_ready
  - out_fire = io_out_valid & io_out_ready
- Storage:
  - main_q is the output register; skid_q is the overflow register.
  - Two valid flags: main_v = io_out_valid, skid_v.
- States, encoded by {skid_v, main_v}:
  - EMPTY = 00, ONE = 01, FULL = 11.
  - 10 is illegal and must never occur. The bench asserts this.
- Reset (reset low at an edge):
  - main_v = 0, skid_v = 0, io_count = 0.
  - io_in_ready = 0 while reset is low; 1 in the first cycle after release.
  - Payload = 0 if DATA_RESET = 1, else don't-care.
- io_in_ready = !skid_v (registered), gated by reset as above.
- Transitions (no flush):
  - EMPTY, in_fire: main_q <= in, go to ONE.
  - ONE, in_fire and out_fire: main_q <= in, stay in ONE.
  - ONE, in_fire and no out_fire: skid_q <= in, go to FULL. io_in_ready drops the next cycle.
  - ONE, out_fire only: go to EMPTY.
  - FULL, out_fire: main_q <= skid_q, go to ONE. io_in_ready rises the next cycle.
  - FULL: in_fire is impossible because io_in_ready = 0.
  - No fire in any state: hold state and payload.
- Ordering: strict FIFO. Data leaves in acceptance order, with no loss or duplication.
- Latency: one cycle from in_fire to io_out_valid when EMPTY. No combinational in-to-out path.
- Throughput: 1 transfer/cycle sustained when the consumer is always ready.
- Flush (io_flush = 1 at an edge):
  - Next state EMPTY. main_v and skid_v clear.
  - In the flush cycle, in_fire and out_fire still complete as handshakes. An accepted input is discarded; an output transfer counts as delivered.
  - io_in_ready = 1 the next cycle.
- Simultaneous flush and reset: reset dominates; the result is identical.
- io_count:
  - Registered encoding of the state: EMPTY = 0, ONE = 1, FULL = 2.
  - Never 3.
- Payload registers load only on their enable, i.e. when the corresponding write occurs. Otherwise they hold, including across flush.
- Handshake rules required of the environment:
  - Producer must hold io_in_valid and io_in_bits until in_fire.
  - The block never drops io_out_valid without out_fire, except via flush or reset.

Decomposition:
- Shared package rvdff_skid_pkg:
  - state encoding constants (EMPTY, ONE, FULL)
  - count width constant (2)
  - default WIDTH
- One natural sub-module: rvdffe, an enabled flop with WIDTH and DATA_RESET parameters.
  - Instantiated twice, for main_q and skid_q.
  - Takes the same clock and synchronous active-low reset.
- The valid/state logic stays in rvdff_skid.

Test Plan:
1. Reset/idle: hold reset low 3 cycles with io_in_valid = 1, bits 0xAAAA.
   - During reset: io_in_ready = 0.
   - After release: io_out_valid = 0, io_count = 0, io_in_ready = 1 on the first cycle.
   - No data is captured from the reset cycles.
2. Streaming: out_ready = 1, send 0x0001..0x0010 on consecutive cycles.
   - Each word appears on io_out_bits exactly 1 cycle after its in_fire.
   - io_count = 1 throughout; io_in_ready stays 1.
3. Backpressure: out_ready = 0, send 0x1111 then 0x2222, then raise out_ready.
   - io_count goes 1 then 2; io_in_ready = 0 the cycle after the second accept.
   - Outputs are 0x1111 then 0x2222 on consecutive cycles.
   - io_in_ready returns to 1 one cycle after the first out_fire.
4. Simultaneous in/out in ONE: main = 0x3333, out_ready = 1, in 0x4444 in the same cycle.
   - Next cycle io_out_bits = 0x4444, io_count = 1, skid unused.
5. Flush while FULL: state FULL with 0x5555 and 0x6666, assert io_flush with out_ready = 1 for one cycle.
   - 0x5555 is delivered in the flush cycle.
   - Next cycle: io_out_valid = 0, io_count = 0, io_in_ready = 1, io_clken = 1 in the flush cycle.
   - 0x6666 never appears.
6. Random valid/ready for 10k cycles, with flush at about 1%.
   - Scoreboard checks in-order, lossless output between flushes.
   - State 10 never occurs; io_count is never 3; io_clken matches in_fire | out_fire | io_flush every cycle.
